// File: rtl/asp_sed_pkg.sv
// Shared types and helpers for the soft-error detector: FSM states, opcode constants and the
// even-parity check used on the stage-1 tap.
package asp_sed_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StAlarm = 2'd2
  } sed_state_e;

  localparam logic [1:0] OPC_NOP = 2'b00;

  // Widest data word the parity helper accepts; narrower words are zero-extended by the caller.
  localparam int unsigned MaxDataW = 256;

  function automatic logic parity_bad(input logic [MaxDataW-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/sed_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sed_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_next_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/soft_error_detector.sv
// Parity checker at the stage-1 tap: flags soft errors, requests flushes and raises a held alarm.
// Define SED_ERR_LOG_EN to add a capture log of the first erroneous word.
module soft_error_detector
  import asp_sed_pkg::*;
#(
  parameter int unsigned data_size  = 32,
  parameter int unsigned tag_size   = 8,
  parameter int unsigned cnt_size   = 8,
  parameter int unsigned err_thresh = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chk_valid_in,
  input  logic [1:0]           opcode_in,
  input  logic [data_size-1:0] data_in,
  input  logic                 parity_in,
  input  logic [tag_size-1:0]  tag_in,
  input  logic                 alarm_ack_in,
  output logic                 err_flag_out,
  output logic                 flush_out,
  output logic                 alarm_out,
  output logic [cnt_size-1:0]  err_count_out,
  output logic                 busy_out
`ifdef SED_ERR_LOG_EN
  ,
  output logic                 log_valid_out,
  output logic [data_size-1:0] log_data_out,
  output logic [tag_size-1:0]  log_tag_out,
  output logic [1:0]           log_opcode_out
`endif
);

  localparam logic [cnt_size-1:0] Thresh = cnt_size'(err_thresh);

  sed_state_e state_d, state_q;
  logic err, ack_acc;
  logic flush_d;
  logic err_flag_q, flush_q, alarm_q, busy_q;
  logic [cnt_size-1:0] count_next;

  assign err = chk_valid_in && (opcode_in != OPC_NOP) &&
               parity_bad(MaxDataW'(data_in), parity_in);
  assign ack_acc = (state_q == StAlarm) && alarm_ack_in;

  sed_sat_counter #(
    .Width(cnt_size)
  ) u_counter (
    .clk_i       (clk),
    .rst_ni      (reset),
    .inc_i       (err),
    .clr_i       (ack_acc),
    .count_o     (err_count_out),
    .count_next_o(count_next)
  );

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (err) begin
          state_d = StFlush;
          flush_d = 1'b1;
        end
      end
      // Decide on the count including any error landing during the flush cycle itself.
      StFlush: state_d = (count_next >= Thresh) ? StAlarm : StIdle;
      StAlarm: begin
        if (alarm_ack_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      err_flag_q <= 1'b0;
      flush_q    <= 1'b0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_flag_q <= err;
      flush_q    <= flush_d;
      alarm_q    <= (state_d == StAlarm);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign err_flag_out = err_flag_q;
  assign flush_out    = flush_q;
  assign alarm_out    = alarm_q;
  assign busy_out     = busy_q;

`ifdef SED_ERR_LOG_EN
  logic                 log_valid_q;
  logic [data_size-1:0] log_data_q;
  logic [tag_size-1:0]  log_tag_q;
  logic [1:0]           log_opcode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      log_valid_q  <= 1'b0;
      log_data_q   <= '0;
      log_tag_q    <= '0;
      log_opcode_q <= '0;
    end else if (ack_acc) begin
      log_valid_q <= 1'b0;
    end else if (err && !log_valid_q) begin
      log_valid_q  <= 1'b1;
      log_data_q   <= data_in;
      log_tag_q    <= tag_in;
      log_opcode_q <= opcode_in;
    end
  end

  assign log_valid_out  = log_valid_q;
  assign log_data_out   = log_data_q;
  assign log_tag_out    = log_tag_q;
  assign log_opcode_out = log_opcode_q;
`else
  logic unused_tag;
  assign unused_tag = ^tag_in;
`endif

endmodule

// File: tb/tb_soft_error_detector.sv
// Bench for soft_error_detector: two instances (default sizing and a 2-bit counter) share
// stimulus and are checked against a behavioural model. Honours SED_ERR_LOG_EN.
module tb_soft_error_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid, par, ack;
  logic [1:0]  op;
  logic [31:0] data;
  logic [7:0]  tag;

  logic       flag_a, flush_a, alarm_a, busy_a;
  logic [7:0] cnt_a;
  logic       flag_b, flush_b, alarm_b, busy_b;
  logic [1:0] cnt_b;
`ifdef SED_ERR_LOG_EN
  logic lv_a, lv_b;
  logic [31:0] ld_a, ld_b;
  logic [7:0] lt_a, lt_b;
  logic [1:0] lo_a, lo_b;
`endif

  soft_error_detector dut_a (
    .clk(clk), .reset(reset), .chk_valid_in(valid), .opcode_in(op), .data_in(data),
    .parity_in(par), .tag_in(tag), .alarm_ack_in(ack), .err_flag_out(flag_a),
    .flush_out(flush_a), .alarm_out(alarm_a), .err_count_out(cnt_a), .busy_out(busy_a)
`ifdef SED_ERR_LOG_EN
    , .log_valid_out(lv_a), .log_data_out(ld_a), .log_tag_out(lt_a), .log_opcode_out(lo_a)
`endif
  );

  soft_error_detector #(
    .data_size(32), .tag_size(8), .cnt_size(2), .err_thresh(3)
  ) dut_b (
    .clk(clk), .reset(reset), .chk_valid_in(valid), .opcode_in(op), .data_in(data),
    .parity_in(par), .tag_in(tag), .alarm_ack_in(ack), .err_flag_out(flag_b),
    .flush_out(flush_b), .alarm_out(alarm_b), .err_count_out(cnt_b), .busy_out(busy_b)
`ifdef SED_ERR_LOG_EN
    , .log_valid_out(lv_b), .log_data_out(ld_b), .log_tag_out(lt_b), .log_opcode_out(lo_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = idle, 1 = flushing, 2 = alarm.
  int cmax[2] = '{255, 3};
  int thr[2]  = '{4, 3};
  int mode[2], cnt[2];
  bit e_flag[2], e_flush[2], e_alarm[2], e_busy[2];
  bit lv[2];
  logic [31:0] ldat[2];
  logic [7:0]  ltag[2];
  logic [1:0]  lop[2];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; cnt[i] = 0; lv[i] = 0;
      e_flag[i] = 0; e_flush[i] = 0; e_alarm[i] = 0; e_busy[i] = 0;
      ldat[i] = '0; ltag[i] = '0; lop[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    bit err, acked;
    int nc, nm;
    err   = valid && (op != 2'b00) && (($countones({data, par}) % 2) == 1);
    acked = (mode[i] == 2) && ack;
    if (acked) nc = 0;
    else if (err) nc = (cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i];
    else nc = cnt[i];
    e_flag[i]  = err;
    e_flush[i] = (mode[i] == 0) && err;
    case (mode[i])
      0:       nm = err ? 1 : 0;
      1:       nm = (nc >= thr[i]) ? 2 : 0;
      default: nm = ack ? 0 : 2;
    endcase
    if (acked) lv[i] = 0;
    else if (err && !lv[i]) begin
      lv[i] = 1; ldat[i] = data; ltag[i] = tag; lop[i] = op;
    end
    mode[i] = nm;
    cnt[i] = nc;
    e_alarm[i] = (nm == 2);
    e_busy[i] = (nm != 0);
  endtask

  task automatic check_all();
    chk("a_flag", 64'(flag_a), 64'(e_flag[0]));
    chk("a_flush", 64'(flush_a), 64'(e_flush[0]));
    chk("a_alarm", 64'(alarm_a), 64'(e_alarm[0]));
    chk("a_busy", 64'(busy_a), 64'(e_busy[0]));
    chk("a_count", 64'(cnt_a), 64'(cnt[0]));
    chk("b_flag", 64'(flag_b), 64'(e_flag[1]));
    chk("b_flush", 64'(flush_b), 64'(e_flush[1]));
    chk("b_alarm", 64'(alarm_b), 64'(e_alarm[1]));
    chk("b_busy", 64'(busy_b), 64'(e_busy[1]));
    chk("b_count", 64'(cnt_b), 64'(cnt[1]));
`ifdef SED_ERR_LOG_EN
    chk("a_log_valid", 64'(lv_a), 64'(lv[0]));
    chk("b_log_valid", 64'(lv_b), 64'(lv[1]));
    if (lv[0]) begin
      chk("a_log_data", 64'(ld_a), 64'(ldat[0]));
      chk("a_log_tag", 64'(lt_a), 64'(ltag[0]));
      chk("a_log_op", 64'(lo_a), 64'(lop[0]));
    end
    if (lv[1]) begin
      chk("b_log_data", 64'(ld_b), 64'(ldat[1]));
      chk("b_log_tag", 64'(lt_b), 64'(ltag[1]));
    end
`endif
  endtask

  // Called at a falling edge: apply inputs, advance model, check at the next falling edge.
  task automatic step(input logic v, input logic [1:0] o, input logic [31:0] d, input logic p,
                      input logic [7:0] t, input logic a);
    valid = v; op = o; data = d; par = p; tag = t; ack = a;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic bad_word(input logic [31:0] d, input logic [7:0] t);
    step(1'b1, 2'b10, d, ($countones(d) % 2) == 0, t, 1'b0);
  endtask

  task automatic ack_once();
    step(1'b0, 2'b00, 32'h0, 1'b0, 8'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic bad;
    reset = 1'b0;
    valid = 0; op = 0; data = 0; par = 0; tag = 0; ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_all();
    idle(1);

    // Good then bad copy of the same word.
    step(1'b1, 2'b01, 32'h0000_0001, 1'b1, 8'h11, 1'b0);
    step(1'b1, 2'b01, 32'h0000_0001, 1'b0, 8'h12, 1'b0);
    chk("first_err_flag", 64'(flag_a), 64'd1);
    chk("first_err_flush", 64'(flush_a), 64'd1);
    idle(1);
    chk("first_err_count", 64'(cnt_a), 64'd1);

    // Bad parity masked by NOP and by valid=0.
    step(1'b1, 2'b00, 32'h0000_0001, 1'b0, 8'h13, 1'b0);
    step(1'b0, 2'b11, 32'h0000_0001, 1'b0, 8'h14, 1'b0);
    chk("masked_count", 64'(cnt_a), 64'd1);

    // Isolated errors up to alarm, long wait without ack, then ack.
    for (int k = 0; k < 3; k++) begin
      bad_word(32'hA5A5_0000 + 32'(k), 8'h20 + 8'(k));
      idle(2);
    end
    chk("alarm_after_4", 64'(alarm_a), 64'd1);
    idle(10);
    chk("alarm_held", 64'(alarm_a), 64'd1);
    ack_once();
    chk("ack_count_clr", 64'(cnt_a), 64'd0);
    chk("ack_idle", 64'(busy_a), 64'd0);

    // Back-to-back errors from idle.
    bad_word(32'h0000_00F1, 8'h31);
    bad_word(32'h0000_00F2, 8'h32);
    idle(2);
    chk("b2b_count", 64'(cnt_a), 64'd2);

    // Saturation of the narrow counter.
    for (int k = 0; k < 5; k++) bad_word(32'h1234_0000 + 32'(k), 8'h40 + 8'(k));
    idle(1);
    chk("sat_b", 64'(cnt_b), 64'd3);
    ack_once();
    idle(1);

    // Drive dut_a into alarm with count 5, then reset asynchronously.
    for (int k = 0; k < 4; k++) begin
      bad_word(32'h0F0F_0000 + 32'(k), 8'h50 + 8'(k));
      idle(2);
    end
    bad_word(32'h0F0F_0010, 8'h5F);
    chk("pre_reset_count", 64'(cnt_a), 64'd5);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_alarm", 64'(alarm_a), 64'd0);
    chk("rst_count", 64'(cnt_a), 64'd0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      d = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), d,
           (($countones(d) % 2) == 1) ^ bad, 8'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
